key_input_conditioner: RTL
==========================

// Module: key_input_conditioner
// PURPOSE
//  Parametrised N-key front-panel conditioner: synchronises, debounces and classifies raw push-buttons.
//  Per key it emits press and release pulses, a long-press pulse, and hold-to-repeat pulses.
//  Sits between board KEY pins and the menu/gain control logic (select/back/up/down).
//  Holding up/down steps gain without repeated presses.
// PARAMETERS
//  N_KEYS          4     number of independent key channels
//  ACTIVE_LOW      1     1: pin low = pressed; 0: pin high = pressed
//  DEBOUNCE_CYCLES 1024  consecutive stable cycles required to accept a level change (>=1)
//  LONG_CYCLES     65536 cycles after o_press at which o_long fires (>=1)
//  REPEAT_DELAY    32768 cycles after o_press of the first o_repeat (>=1)
//  REPEAT_PERIOD   8192  cycles between subsequent o_repeat pulses (>=1)
// PORTS
//  i_clk        in   1       single clock, all logic rising-edge
//  i_rst        in   1       synchronous reset, active-high
//  i_keys       in   N_KEYS  raw asynchronous key pins
//  i_repeat_en  in   N_KEYS  per-key auto-repeat enable, sampled every cycle
//  o_level      out  N_KEYS  debounced level, 1 = pressed
//  o_press      out  N_KEYS  1-cycle pulse on accepted press
//  o_release    out  N_KEYS  1-cycle pulse on accepted release
//  o_long       out  N_KEYS  1-cycle pulse, at most once per hold
//  o_repeat     out  N_KEYS  1-cycle pulse train while held and enabled
//  o_any_held   out  1       OR of o_level
// BEHAVIOUR
//  Reset:
//   - all outputs 0; synchroniser FFs load the "released" value; FSMs go to RELEASED; counters 0.
//   - A key held through reset is re-detected after debounce and yields o_press.
//  Sync:
//   - 2-FF synchroniser per key, then polarity normalised to p (1 = pressed).
//  Per-key FSM (all outputs registered):
//   - RELEASED: p=1 -> PRESS_PEND, deb_cnt=1.
//   - PRESS_PEND: p=0 -> RELEASED (bounce, counter cleared). deb_cnt==DEBOUNCE_CYCLES -> HELD, o_level=1, o_press=1, hold_cnt=0.
//   - HELD: p=0 -> RELEASE_PEND, deb_cnt=1. The timing rules below apply while in HELD.
//   - RELEASE_PEND: p=1 -> HELD (bounce; hold_cnt keeps counting, no new o_press). deb_cnt==DEBOUNCE_CYCLES -> RELEASED, o_level=0, o_release=1.
//  Latency:
//   - Clean edge: o_press/o_release asserts exactly DEBOUNCE_CYCLES+2 cycles after the first edge sampling the new pin level.
//  Timing while held:
//   - hold_cnt increments every cycle in HELD/RELEASE_PEND and saturates at max(LONG_CYCLES, REPEAT_DELAY).
//   - o_long=1 in the cycle hold_cnt==LONG_CYCLES.
//   - o_repeat=1 when hold_cnt==REPEAT_DELAY, then every REPEAT_PERIOD cycles via a separate rep_cnt (wraps 0..REPEAT_PERIOD-1).
//   - o_repeat is gated by the current i_repeat_en. Deasserting it suppresses pulses, but rep_cnt keeps its phase.
//   - No o_repeat or o_long is generated in RELEASE_PEND.
//   - Entering RELEASED clears hold_cnt and rep_cnt; a release before LONG_CYCLES means no o_long.
//  Simultaneous events:
//   - Channels are fully independent.
//   - o_long and o_repeat may assert in the same cycle.
//   - o_press and o_release never assert in the same cycle for one key.
//  Widths:
//   - Counters use $clog2(param+1) bits; no arithmetic overflow is possible.
//  Reset mid-hold:
//   - Aborts silently, with no o_release.
// STRUCTURE
//  key_cond_pkg:
//   - typedef enum logic [1:0] {RELEASED, PRESS_PEND, HELD, RELEASE_PEND} key_state_t
//   - function cnt_w(int max) returning $clog2(max+1)
//  Sub-module key_channel:
//   - one key's sync, FSM and counters; instantiated N_KEYS times in a generate loop.
//   - top level adds the o_any_held OR-reduce only.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1)
//  - Clean press: key0 low from cycle 0 -> o_press[0] at cycle 6; o_level[0]=1 from cycle 6.
//    Release at cycle 40 -> o_release[0] at cycle 46.
//  - Bounce: key1 low 3 cycles, high 1, low held -> no pulse until 4 consecutive low samples; exactly one o_press[1].
//  - Repeat: key2 held 40 cycles with i_repeat_en[2]=1 -> o_repeat at hold_cnt 10,13,16,19,22,25,28,31,34 plus while still held;
//    o_long once at hold_cnt 20; with i_repeat_en=0 -> zero o_repeat.
//  - Short hold: key3 held 15 cycles after o_press -> no o_long, o_release follows; o_any_held drops with o_level[3].
//  - Simultaneous: all 4 keys pressed same cycle -> all o_press same cycle. i_rst mid-hold -> all outputs 0 next cycle, no o_release.
//    Keys still low after reset -> o_press DEBOUNCE_CYCLES+2 cycles later.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key input conditioner.
// Defines the per-key FSM state encoding and the counter width helper.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-FF synchroniser, debounce FSM, and the hold timers
// that produce long-press and auto-repeat pulses.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int LONG_CYCLES     = 65536,
  parameter int REPEAT_DELAY    = 32768,
  parameter int REPEAT_PERIOD   = 8192
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
  localparam int DEB_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W   = cnt_w(HOLD_MAX);
  localparam int REP_W    = cnt_w(REPEAT_PERIOD);

  localparam logic              IDLE_LVL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DEB_W-1:0]  DEB_END       = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_TOP      = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LONG_PRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_REP_PRE  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_REP      = HOLD_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0]  REP_TOP       = REP_W'(REPEAT_PERIOD - 1);

  logic              r_sync1, r_sync2;
  key_state_t        r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;

  logic              w_p;
  key_state_t        w_state_nxt;
  logic [DEB_W-1:0]  w_deb_nxt;
  logic [HOLD_W-1:0] w_hold_nxt, w_hold_inc;
  logic [REP_W-1:0]  w_rep_nxt, w_rep_inc;
  logic              w_timing, w_press, w_release, w_long, w_repeat;

  assign w_p = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Next-state, counter and pulse decode; pulses are judged against the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_timing    = 1'b0;
    w_press     = 1'b0;
    w_release   = 1'b0;
    if (r_hold_cnt == HOLD_TOP) begin
      w_hold_inc = r_hold_cnt;
    end else begin
      w_hold_inc = r_hold_cnt + HOLD_W'(1);
    end
    if (r_hold_cnt < HOLD_REP) begin
      w_rep_inc = '0;
    end else if (r_rep_cnt == REP_TOP) begin
      w_rep_inc = '0;
    end else begin
      w_rep_inc = r_rep_cnt + REP_W'(1);
    end
    case (r_state)
      RELEASED: begin
        w_hold_nxt = '0;
        w_rep_nxt  = '0;
        if (w_p) begin
          w_state_nxt = PRESS_PEND;
          w_deb_nxt   = DEB_W'(1);
        end else begin
          w_deb_nxt   = '0;
        end
      end
      PRESS_PEND: begin
        if (!w_p) begin
          w_state_nxt = RELEASED;
          w_deb_nxt   = '0;
        end else if (r_deb_cnt == DEB_END) begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
          w_press     = 1'b1;
        end else begin
          w_deb_nxt   = r_deb_cnt + DEB_W'(1);
        end
      end
      HELD: begin
        w_timing   = 1'b1;
        w_hold_nxt = w_hold_inc;
        w_rep_nxt  = w_rep_inc;
        if (!w_p) begin
          w_state_nxt = RELEASE_PEND;
          w_deb_nxt   = DEB_W'(1);
        end else begin
          w_deb_nxt   = '0;
        end
      end
      RELEASE_PEND: begin
        w_timing   = 1'b1;
        w_hold_nxt = w_hold_inc;
        w_rep_nxt  = w_rep_inc;
        if (w_p) begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
        end else if (r_deb_cnt == DEB_END) begin
          w_state_nxt = RELEASED;
          w_deb_nxt   = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
          w_release   = 1'b1;
        end else begin
          w_deb_nxt   = r_deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_deb_nxt   = '0;
        w_hold_nxt  = '0;
        w_rep_nxt   = '0;
      end
    endcase
    w_long   = w_timing && (w_state_nxt == HELD) && (r_hold_cnt == HOLD_LONG_PRE);
    w_repeat = w_timing && (w_state_nxt == HELD) && i_repeat_en &&
               ((r_hold_cnt == HOLD_REP_PRE) || ((r_hold_cnt >= HOLD_REP) && (w_rep_inc == '0)));
  end

  // Synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= IDLE_LVL;
      r_sync2    <= IDLE_LVL;
      r_state    <= RELEASED;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      o_level    <= 1'b0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
      o_long     <= 1'b0;
      o_repeat   <= 1'b0;
    end else begin
      r_sync1    <= i_key;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      o_level    <= (w_state_nxt == HELD) || (w_state_nxt == RELEASE_PEND);
      o_press    <= w_press;
      o_release  <= w_release;
      o_long     <= w_long;
      o_repeat   <= w_repeat;
    end
  end

endmodule

// File: rtl/key_input_conditioner.sv
// N-key front-panel conditioner: one independent key_channel per key plus
// an any-key-held summary.
module key_input_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int LONG_CYCLES     = 65536,
  parameter int REPEAT_DELAY    = 32768,
  parameter int REPEAT_PERIOD   = 8192
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_keys,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_held
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key       (i_keys[g]),
      .i_repeat_en (i_repeat_en[g]),
      .o_level     (o_level[g]),
      .o_press     (o_press[g]),
      .o_release   (o_release[g]),
      .o_long      (o_long[g]),
      .o_repeat    (o_repeat[g])
    );
  end

  assign o_any_held = |o_level;

endmodule
